hilo_mdu: RTL
=============

// Module: hilo_mdu
// PURPOSE
//  Parametrised HI/LO unit with integrated multiply/divide engine for the MIPS core.
//  Executes MULT/MULTU (pipelined, fixed latency) and DIV/DIVU (iterative restoring, one bit per cycle).
//  Also executes MTHI/MTLO writes and holds the architectural HI/LO pair.
//  Sits beside the EX stage; busy stalls the pipeline, cancel aborts the op on an exception flush.
// PARAMETERS
//  WIDTH       32  operand / HI / LO width in bits (even, >=8)
//  MUL_STAGES  2   multiply latency in cycles from accept to HI/LO write (>=1)
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      synchronous reset, active-low (rst==0 resets on posedge clk)
//  start         in   1      op request; accepted only when busy==0
//  op            in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  a_i           in   WIDTH  multiplicand / dividend / MTHI,MTLO data
//  b_i           in   WIDTH  multiplier / divisor
//  cancel        in   1      abort in-flight or same-cycle op; HI/LO left unchanged
//  busy          out  1      mul/div in flight; start ignored while high
//  done          out  1      one-cycle pulse: mul/div result committed (or div-by-zero finished)
//  div_by_zero   out  1      valid with done; 1 = DIV/DIVU with b_i==0
//  hi_o, lo_o    out  WIDTH  current HI / LO register values
// BEHAVIOUR
//  - Reset (rst==0 at posedge): hi=lo=0, busy=0, done=0, div_by_zero=0, FSM->IDLE.
//    Reset overrides start/cancel. Reset mid-op discards the op.
//  - FSM states: IDLE, MUL, DIV, FIX.
//    IDLE -start&mul-> MUL. IDLE -start&div-> DIV. DIV -WIDTH iterations-> FIX. MUL/FIX -> IDLE.
//  - Accept: start&!busy&!cancel at posedge k. a_i, b_i, op are latched. Later input changes are ignored.
//  - MTHI/MTLO: hi (lo) <= a_i at edge k. New value is visible on the cycle after edge k.
//    busy stays 0, done is not pulsed, the other register is unchanged.
//  - No-op codes (11x): accepted, no effect, busy stays 0.
//  - MULT/MULTU: full 2*WIDTH product; MULT is signed, MULTU unsigned. {hi,lo} <= product at edge k+MUL_STAGES.
//    busy=1 from edge k until edge k+MUL_STAGES. done=1 for one cycle after the write edge, with busy=0 in that cycle.
//  - DIV/DIVU: LO=quotient, HI=remainder, written at edge k+WIDTH+1.
//    WIDTH restoring iterations on magnitudes, then one FIX cycle for sign correction.
//    Signed sign rules: quotient negated iff operand signs differ; remainder takes the dividend's sign.
//    Truncation is toward zero. Signed MIN/-1 gives LO=MIN, HI=0 (wraps, no trap).
//    DIVU: no sign handling.
//  - Divide by zero: busy for 1 cycle, then IDLE. HI/LO unchanged. done=1 and div_by_zero=1 together.
//  - div_by_zero is 0 whenever done is 0.
//  - cancel: in IDLE it suppresses acceptance, including MTHI/MTLO writes.
//    While busy, it returns the FSM to IDLE at the next edge: no write, no done.
//    cancel in the final busy cycle still suppresses the write. cancel while done is pulsing has no effect.
//  - start while busy is ignored and does not queue.
//    start in the done cycle is legal (busy==0) and is accepted.
//  - hi_o/lo_o are driven directly from the registers (no bypass of in-flight results).
// TESTING
//  1. MTHI a=0x1234_5678, then MTLO a=0x9ABC_DEF0 -> hi_o/lo_o update one cycle after each; busy/done stay 0.
//  2. MULT a=0xFFFF_FFFE(-2), b=3 -> after 2 cycles hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, done pulse;
//     MULTU same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
//  3. DIV a=-7, b=2 -> lo=0xFFFF_FFFD(-3), hi=0xFFFF_FFFF(-1), done at cycle WIDTH+1;
//     DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//  4. DIVU a=100, b=0 with hi=lo=0x55 -> one busy cycle, done=1, div_by_zero=1; hi=lo=0x55 retained.
//  5. DIVU 100/7 with cancel at cycle 10, then start during busy -> no write, no done;
//     start during busy ignored; next start after busy=0 runs normally (lo=14, hi=2).
//  6. rst=0 mid-MULT and mid-DIV -> all outputs 0 next cycle, FSM IDLE;
//     rst=0 with start=1 -> op not accepted.

Source files
------------

// File: rtl/hilo_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_mdu_if
//  Purpose  : Request/response bundle between the EX stage and the HI/LO unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, op, a_i, b_i, cancel,
        input  busy, done, div_by_zero, hi_o, lo_o
    );

    modport slave (
        input  start, op, a_i, b_i, cancel,
        output busy, done, div_by_zero, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_mdu
//  Purpose  : Architectural HI/LO pair with fixed-latency multiply and
//             one-bit-per-cycle restoring divide.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hilo_mdu_if.slave   bus
);
    localparam int c_CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CW-1:0] c_MUL_LAST = c_CW'(MUL_STAGES - 1);
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dz;
    logic               r_dz_pend;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_accept;
    logic               w_op_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_accept    = bus.start & (r_state == S_IDLE) & ~bus.cancel;
    assign w_op_signed = ~bus.op[0];
    assign w_a_neg     = w_op_signed & bus.a_i[WIDTH-1];
    assign w_b_neg     = w_op_signed & bus.b_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (-bus.a_i) : bus.a_i;
    assign w_b_mag     = w_b_neg ? (-bus.b_i) : bus.b_i;

    // Sign-extending to 2*WIDTH lets one multiplier serve MULT and MULTU.
    assign w_ma   = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mb   = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ma * w_mb;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    assign w_q_fix = r_neg_q ? (-r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (-r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            3'b000, 3'b001: begin
                                r_a      <= bus.a_i;
                                r_b      <= bus.b_i;
                                r_signed <= w_op_signed;
                                r_cnt    <= '0;
                                r_state  <= S_MUL;
                            end
                            3'b010, 3'b011: begin
                                r_quo     <= w_a_mag;
                                r_dvs     <= w_b_mag;
                                r_rem     <= '0;
                                r_neg_q   <= w_a_neg ^ w_b_neg;
                                r_neg_r   <= w_a_neg;
                                r_cnt     <= '0;
                                r_dz_pend <= (bus.b_i == '0);
                                // A zero divisor skips the iterations entirely.
                                r_state   <= (bus.b_i == '0) ? S_FIX : S_DIV;
                            end
                            3'b100:  r_hi <= bus.a_i;
                            3'b101:  r_lo <= bus.a_i;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (bus.cancel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_MUL_LAST) begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (bus.cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_fits};
                        if (r_cnt == c_DIV_LAST) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        if (r_dz_pend) begin
                            r_dz <= 1'b1;
                        end else begin
                            r_lo <= w_q_fix;
                            r_hi <= w_r_fix;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dz;
    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;
endmodule
`default_nettype wire
